// File: rtl/int_sched_if.sv
// Register bus and interrupt request/acknowledge handshake between int_sched and its host/clint.
interface int_sched_if;
  logic        we_i;
  logic        re_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        int_req_o;
  logic [31:0] int_cause_o;
  logic        int_ack_i;
  logic        int_done_i;

  modport slave (
    input  we_i, re_i, addr_i, wdata_i, int_ack_i, int_done_i,
    output rdata_o, int_req_o, int_cause_o
  );

  modport master (
    output we_i, re_i, addr_i, wdata_i, int_ack_i, int_done_i,
    input  rdata_o, int_req_o, int_cause_o
  );
endinterface

// File: rtl/int_sched.sv
// Machine-level interrupt source controller: mtime/mtimecmp timer, msip, edge-latched external
// lines, and a one-at-a-time request/ack/mret scheduler towards clint.
module int_sched #(
  parameter int NUM_EXT  = 4,
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXT-1:0] ext_irq_i,
  input  logic [31:0]        mie_i,
  input  logic               global_int_en_i,
  output logic [31:0]        mip_o,
  int_sched_if.slave         bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SVC  = 2'd2;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               msip;
  logic [NUM_EXT-1:0] ext_en;
  logic [NUM_EXT-1:0] ext_pend;
  logic [NUM_EXT-1:0] ext_prev;
  logic [PW-1:0]      presc;
  logic [31:0]        rdata;
  logic [31:0]        mip;
  logic [1:0]         state;
  logic               req;
  logic [31:0]        cause;

  logic               tick;
  logic [NUM_EXT-1:0] pend_en;
  logic [NUM_EXT-1:0] claim_hit;
  logic [NUM_EXT-1:0] claim_clr;
  logic [31:0]        claim_id;
  logic               claim_found;
  logic [31:0]        rd_val;
  logic [31:0]        cand;
  logic               cand_any;
  logic [31:0]        cand_cause;
  logic               unused_mie;

  assign tick      = (presc == PMAX);
  assign pend_en   = ext_pend & ext_en;
  assign claim_clr = (bus.re_i && bus.addr_i == 8'h1C) ? claim_hit : '0;
  assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_comb begin
    claim_hit   = '0;
    claim_id    = '0;
    claim_found = 1'b0;
    for (int unsigned i = 0; i < NUM_EXT; i++) begin
      if (!claim_found && pend_en[i]) begin
        claim_found  = 1'b1;
        claim_hit[i] = 1'b1;
        claim_id     = i + 1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr_i)
      8'h00:   rd_val = mtime[31:0];
      8'h04:   rd_val = mtime[63:32];
      8'h08:   rd_val = mtimecmp[31:0];
      8'h0C:   rd_val = mtimecmp[63:32];
      8'h10:   rd_val = {31'd0, msip};
      8'h14:   rd_val = 32'(ext_en);
      8'h18:   rd_val = 32'(ext_pend);
      8'h1C:   rd_val = claim_id;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      mtime <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      // A write to either half takes precedence over the tick for the whole counter.
      if (bus.we_i && bus.addr_i == 8'h00)
        mtime[31:0] <= bus.wdata_i;
      else if (bus.we_i && bus.addr_i == 8'h04)
        mtime[63:32] <= bus.wdata_i;
      else if (tick)
        mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
      ext_en   <= '0;
      ext_pend <= '0;
      ext_prev <= '0;
      rdata    <= '0;
      mip      <= '0;
    end else begin
      if (bus.we_i && bus.addr_i == 8'h08) mtimecmp[31:0]  <= bus.wdata_i;
      if (bus.we_i && bus.addr_i == 8'h0C) mtimecmp[63:32] <= bus.wdata_i;
      if (bus.we_i && bus.addr_i == 8'h10) msip            <= bus.wdata_i[0];
      if (bus.we_i && bus.addr_i == 8'h14) ext_en          <= bus.wdata_i[NUM_EXT-1:0];
      ext_prev <= ext_irq_i;
      ext_pend <= (ext_pend & ~claim_clr) | (ext_irq_i & ~ext_prev);
      if (bus.re_i) rdata <= rd_val;
      mip <= {20'd0, |pend_en, 3'd0, (mtime >= mtimecmp), 3'd0, msip, 3'd0};
    end
  end

  assign cand     = mip & mie_i;
  assign cand_any = cand[11] | cand[3] | cand[7];

  always_comb begin
    if (cand[11])      cand_cause = 32'h8000_000B;
    else if (cand[3])  cand_cause = 32'h8000_0003;
    else               cand_cause = 32'h8000_0007;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      cause <= '0;
    end else begin
      case (state)
        IDLE: if (global_int_en_i && cand_any) begin
          state <= REQ;
          req   <= 1'b1;
          cause <= cand_cause;
        end
        REQ: if (bus.int_ack_i) begin
          state <= SVC;
          req   <= 1'b0;
        end
        SVC: if (bus.int_done_i) state <= IDLE;
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign mip_o           = mip;
  assign bus.rdata_o     = rdata;
  assign bus.int_req_o   = req;
  assign bus.int_cause_o = cause;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: register map, timer, priority, claim and scheduler handshake.
module tb_int_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ext_irq, ext_irq4;
  logic [31:0] mie, mie4, mip, mip4;
  logic        gie, gie4;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  int_sched_if bus1();
  int_sched_if bus4();

  int_sched #(.NUM_EXT(4), .TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .ext_irq_i(ext_irq), .mie_i(mie),
    .global_int_en_i(gie), .mip_o(mip), .bus(bus1)
  );

  int_sched #(.NUM_EXT(4), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .ext_irq_i(ext_irq4), .mie_i(mie4),
    .global_int_en_i(gie4), .mip_o(mip4), .bus(bus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input bit d4, input logic [7:0] a, input logic [31:0] d);
    if (d4) begin bus4.we_i = 1'b1; bus4.addr_i = a; bus4.wdata_i = d; end
    else    begin bus1.we_i = 1'b1; bus1.addr_i = a; bus1.wdata_i = d; end
    @(negedge clk);
    bus1.we_i = 1'b0;
    bus4.we_i = 1'b0;
  endtask

  task automatic bus_read(input bit d4, input logic [7:0] a, output logic [31:0] d);
    if (d4) begin bus4.re_i = 1'b1; bus4.addr_i = a; end
    else    begin bus1.re_i = 1'b1; bus1.addr_i = a; end
    @(negedge clk);
    bus1.re_i = 1'b0;
    bus4.re_i = 1'b0;
    d = d4 ? bus4.rdata_o : bus1.rdata_o;
  endtask

  task automatic pulse_ack();
    bus1.int_ack_i = 1'b1;
    @(negedge clk);
    bus1.int_ack_i = 1'b0;
  endtask

  task automatic pulse_done();
    bus1.int_done_i = 1'b1;
    @(negedge clk);
    bus1.int_done_i = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (bus1.int_req_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v, v2;
    logic [31:0] s [9];
    int n, ticks, bad;

    ext_irq = '0; ext_irq4 = '0; mie = '0; mie4 = '0; gie = 1'b0; gie4 = 1'b0;
    bus1.we_i = 0; bus1.re_i = 0; bus1.addr_i = '0; bus1.wdata_i = '0;
    bus1.int_ack_i = 0; bus1.int_done_i = 0;
    bus4.we_i = 0; bus4.re_i = 0; bus4.addr_i = '0; bus4.wdata_i = '0;
    bus4.int_ack_i = 0; bus4.int_done_i = 0;

    repeat (3) @(negedge clk);
    chk("rst_rdata", bus1.rdata_o, 32'h0);
    chk("rst_mip", mip, 32'h0);
    chk("rst_req", {31'd0, bus1.int_req_o}, 32'h0);
    chk("rst_cause", bus1.int_cause_o, 32'h0);
    rst = 1'b0;

    bus_read(0, 8'h00, v); chk("mtime_lo_0", v, 32'd0);
    bus_read(0, 8'h00, v); chk("mtime_lo_1", v, 32'd1);
    bus_read(0, 8'h04, v); chk("mtime_hi", v, 32'd0);
    bus_read(0, 8'h08, v); chk("mtimecmp_lo", v, 32'hFFFF_FFFF);
    bus_read(0, 8'h0C, v); chk("mtimecmp_hi", v, 32'hFFFF_FFFF);
    bus_read(0, 8'h10, v); chk("msip_rst", v, 32'h0);
    bus_read(0, 8'h14, v); chk("ext_en_rst", v, 32'h0);
    bus_read(0, 8'h18, v); chk("ext_pend_rst", v, 32'h0);
    bus_read(0, 8'h1C, v); chk("claim_rst", v, 32'h0);
    bus_write(0, 8'h24, 32'hDEAD_BEEF);
    bus_read(0, 8'h24, v); chk("unmapped", v, 32'h0);

    // TICK_DIV=4 instance: exactly two increments across eight consecutive cycles
    bus4.re_i = 1'b1; bus4.addr_i = 8'h00;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s[i] = bus4.rdata_o;
    end
    bus4.re_i = 1'b0;
    ticks = 0; bad = 0;
    for (int i = 1; i < 9; i++) begin
      if (s[i] - s[i-1] == 32'd1) ticks++;
      else if (s[i] != s[i-1]) bad++;
    end
    chk("tick4_count", ticks, 32'd2);
    chk("tick4_steps", bad, 32'd0);
    bus_write(1, 8'h04, 32'd1);
    bus_read(1, 8'h04, v); chk("tick4_hi_write", v, 32'd1);

    // Timer interrupt
    gie = 1'b1;
    bus_write(0, 8'h08, 32'd10);
    bus_write(0, 8'h0C, 32'd0);
    bus_write(0, 8'h00, 32'd0);
    n = 0;
    repeat (2) begin @(negedge clk); n++; end
    mie = 32'h80;
    while (bus1.int_req_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("timer_latency", n, 32'd12);
    chk("timer_cause", bus1.int_cause_o, 32'h8000_0007);
    chk("timer_mip", mip, 32'h80);
    gie = 1'b0;
    pulse_done();
    repeat (3) @(negedge clk);
    chk("req_hold_mie0", {31'd0, bus1.int_req_o}, 32'd1);
    chk("cause_hold", bus1.int_cause_o, 32'h8000_0007);
    pulse_ack();
    chk("ack_clears_req", {31'd0, bus1.int_req_o}, 32'd0);
    pulse_ack();
    pulse_done();
    repeat (3) @(negedge clk);
    chk("gie0_no_req", {31'd0, bus1.int_req_o}, 32'd0);
    gie = 1'b1;
    @(negedge clk);
    chk("gie1_req", {31'd0, bus1.int_req_o}, 32'd1);
    bus1.int_ack_i = 1'b1; bus1.int_done_i = 1'b1;
    @(negedge clk);
    bus1.int_ack_i = 1'b0; bus1.int_done_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("ack_done_same_cycle", {31'd0, bus1.int_req_o}, 32'd0);
    bus_write(0, 8'h0C, 32'hFFFF_FFFF);
    pulse_done();
    repeat (3) @(negedge clk);
    chk("timer_cleared", {31'd0, bus1.int_req_o}, 32'd0);

    // MEI beats MSI when both rise together
    mie = 32'h888;
    bus_write(0, 8'h14, 32'h1);
    ext_irq = 4'b0001;
    bus_write(0, 8'h10, 32'h1);
    wait_req(n);
    chk("prio_latency", n, 32'd2);
    chk("prio_cause_mei", bus1.int_cause_o, 32'h8000_000B);
    chk("prio_mip", mip, 32'h808);
    pulse_ack();
    bus_read(0, 8'h1C, v); chk("claim_ext0", v, 32'd1);
    pulse_done();
    wait_req(n);
    chk("msi_req", {31'd0, bus1.int_req_o}, 32'd1);
    chk("msi_cause", bus1.int_cause_o, 32'h8000_0003);
    pulse_ack();
    bus_write(0, 8'h10, 32'h0);
    pulse_done();
    ext_irq = '0;
    repeat (3) @(negedge clk);
    chk("all_cleared", {31'd0, bus1.int_req_o}, 32'd0);

    // Claim ordering
    gie = 1'b0;
    bus_write(0, 8'h14, 32'hF);
    ext_irq = 4'b0110; @(negedge clk);
    ext_irq = 4'b0000; @(negedge clk);
    bus_read(0, 8'h18, v); chk("pend_12", v, 32'h6);
    bus_read(0, 8'h1C, v); chk("claim_a", v, 32'd2);
    bus_read(0, 8'h18, v); chk("pend_2", v, 32'h4);
    bus_read(0, 8'h1C, v); chk("claim_b", v, 32'd3);
    bus_read(0, 8'h1C, v); chk("claim_c", v, 32'd0);
    bus_read(0, 8'h18, v); chk("pend_none", v, 32'h0);
    ext_irq = 4'b0010; @(negedge clk);
    ext_irq = 4'b0000; @(negedge clk);
    ext_irq = 4'b0010;
    bus_read(0, 8'h1C, v); chk("claim_set_race", v, 32'd2);
    ext_irq = 4'b0000;
    bus_read(0, 8'h18, v); chk("set_wins", v, 32'h2);
    bus_read(0, 8'h1C, v); chk("claim_again", v, 32'd2);
    bus_write(0, 8'h14, 32'h1);
    ext_irq = 4'b1000; @(negedge clk);
    ext_irq = 4'b0000;
    bus_read(0, 8'h1C, v); chk("claim_disabled", v, 32'd0);
    bus_read(0, 8'h18, v); chk("pend_disabled", v, 32'h8);

    // Writing mtime_hi suppresses that cycle's increment
    bus_read(0, 8'h00, v);
    bus_write(0, 8'h04, 32'd1);
    bus_read(0, 8'h00, v2); chk("hi_write_no_inc", v2, v + 32'd1);
    bus_read(0, 8'h04, v); chk("hi_write_val", v, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
